// File: rtl/patbuf_ctrl_if.sv
// Bundle of every non-clock/reset signal of the pattern field buffer
// controller: host fill stream, host drain stream, core handshake and the
// 1R1W field memory ports.
//
//   slave  : the controller side (patbuf_ctrl)
//   master : the environment side (host streams, pat core, field memory)
//
// Signal summary (controller view):
//   in_valid/in_ready/in_data          fill stream, one field per handshake
//   out_valid/out_ready/out_data/last  drain stream, out_last on field NF-1
//   bufp/core_go/core_busy/core_done   core ownership handshake
//   core_re/fieldp/field_in            core read request, index and data
//   core_we/fieldwp/core_wdata         core write request, index and data
//   mem_re/mem_radr/mem_rdata          memory read port (1-cycle latency)
//   mem_we/mem_wadr/mem_wdata          memory write port
//   occ                                buffers not free (0..NBUF)
interface patbuf_ctrl_if #(
   parameter int bufp_width   = 3,
   parameter int fieldp_width = 5,
   parameter int buffer_width = 8
);
   logic                                 in_valid;
   logic                                 in_ready;
   logic [buffer_width-1:0]              in_data;
   logic                                 out_valid;
   logic                                 out_ready;
   logic [buffer_width-1:0]              out_data;
   logic                                 out_last;
   logic [bufp_width-1:0]                bufp;
   logic                                 core_go;
   logic                                 core_busy;
   logic                                 core_done;
   logic                                 core_re;
   logic [fieldp_width-1:0]              fieldp;
   logic [fieldp_width-1:0]              fieldwp;
   logic                                 core_we;
   logic [buffer_width-1:0]              core_wdata;
   logic [buffer_width-1:0]              field_in;
   logic                                 mem_re;
   logic [bufp_width+fieldp_width-1:0]   mem_radr;
   logic [buffer_width-1:0]              mem_rdata;
   logic                                 mem_we;
   logic [bufp_width+fieldp_width-1:0]   mem_wadr;
   logic [buffer_width-1:0]              mem_wdata;
   logic [bufp_width:0]                  occ;

   modport slave (
      input  in_valid, in_data, out_ready, core_done, core_re, fieldp,
             fieldwp, core_we, core_wdata, mem_rdata,
      output in_ready, out_valid, out_data, out_last, bufp, core_go,
             core_busy, field_in, mem_re, mem_radr, mem_we, mem_wadr,
             mem_wdata, occ
   );

   modport master (
      output in_valid, in_data, out_ready, core_done, core_re, fieldp,
             fieldwp, core_we, core_wdata, mem_rdata,
      input  in_ready, out_valid, out_data, out_last, bufp, core_go,
             core_busy, field_in, mem_re, mem_radr, mem_we, mem_wadr,
             mem_wdata, occ
   );
endinterface

// File: rtl/patbuf_ctrl.sv
// Buffer-ring controller for the pattern field buffer. Owns a 1R1W memory of
// NBUF buffers x NF fields and moves every buffer through host fill -> core
// processing -> host drain in strict ring order. The core always wins the
// memory ports over the stream engines.
//
// Ports:
//   clk    clock, all state changes on posedge
//   reset  asynchronous active-low reset
//   bus    patbuf_ctrl_if.slave: fill/drain streams, core handshake, memory
//
// Core FSM
//   state      | meaning
//   st_c_idle  | core owns nothing; waits for a filled buffer
//   st_c_run   | core owns bufp until core_done; core_go on first cycle
//
// Drain FSM
//   state      | meaning
//   st_d_idle  | no buffer being drained; waits for a processed buffer
//   st_d_run   | reading drain_buf into the skid FIFO until out_last leaves
module patbuf_ctrl #(
   parameter int bufp_width   = 3,
   parameter int fieldp_width = 5,
   parameter int buffer_width = 8
) (
   input logic          clk,
   input logic          reset,
   patbuf_ctrl_if.slave bus
);
   localparam int nbuf = 1 << bufp_width;
   localparam int nf   = 1 << fieldp_width;
   localparam int cw   = bufp_width + 1;
   localparam logic [fieldp_width-1:0] last_idx = fieldp_width'(nf - 1);
   localparam logic [cw-1:0]           nbuf_c   = cw'(nbuf);

   typedef enum logic {st_c_idle, st_c_run} core_state_t;
   typedef enum logic {st_d_idle, st_d_run} drain_state_t;

   core_state_t  core_state, core_state_nx;
   drain_state_t drain_state, drain_state_nx;

   logic [bufp_width-1:0]   fill_buf, core_buf, drain_buf;
   logic [fieldp_width-1:0] fill_idx, drain_rd_idx;
   logic                    drain_rd_all;
   logic [cw-1:0]           occ_q, ready_cnt, proc_cnt;
   logic                    core_first;

   logic                    rd_inflight, rd_inflight_last;
   logic [1:0]              sk_cnt;
   logic [buffer_width-1:0] sk_data0, sk_data1;
   logic                    sk_last0, sk_last1;

   logic core_busy, core_wr, core_rd;
   logic in_ready_c, fill_fire, fill_done;
   logic core_start, core_finish;
   logic drain_start, drain_done, drain_issue;
   logic out_valid_c, out_fire;
   logic [2:0] skid_load;
   logic [1:0] sk_cnt_popped;

   assign core_busy  = (core_state == st_c_run);
   assign core_wr    = core_busy && bus.core_we;
   assign core_rd    = core_busy && bus.core_re;

   // reset gates in_ready so no fill handshake can be seen while held in reset
   assign in_ready_c = reset && (occ_q < nbuf_c) && !core_wr;
   assign fill_fire  = bus.in_valid && in_ready_c;
   assign fill_done  = fill_fire && (fill_idx == last_idx);

   assign out_valid_c = (sk_cnt != 2'd0);
   assign out_fire    = out_valid_c && bus.out_ready;
   assign drain_done  = out_fire && sk_last0;

   // Occupancy after this cycle's pop: counting the pop lets the drain keep
   // one field per cycle while still never holding more than two fields.
   assign skid_load = {1'b0, sk_cnt} + {2'b00, rd_inflight} - {2'b00, out_fire};
   assign drain_issue = (drain_state == st_d_run) && !core_rd && !drain_rd_all
                        && (skid_load < 3'd2);

   always_comb begin
      core_state_nx = core_state;
      core_start    = 1'b0;
      core_finish   = 1'b0;
      case (core_state)
         st_c_idle: begin
            if (ready_cnt != '0) begin
               core_state_nx = st_c_run;
               core_start    = 1'b1;
            end
         end
         st_c_run: begin
            if (bus.core_done) begin
               core_state_nx = st_c_idle;
               core_finish   = 1'b1;
            end
         end
         default: core_state_nx = st_c_idle;
      endcase
   end

   always_comb begin
      drain_state_nx = drain_state;
      drain_start    = 1'b0;
      case (drain_state)
         st_d_idle: begin
            if (proc_cnt != '0) begin
               drain_state_nx = st_d_run;
               drain_start    = 1'b1;
            end
         end
         st_d_run: begin
            if (drain_done) drain_state_nx = st_d_idle;
         end
         default: drain_state_nx = st_d_idle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         core_state  <= st_c_idle;
         drain_state <= st_d_idle;
      end else begin
         core_state  <= core_state_nx;
         drain_state <= drain_state_nx;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fill_buf   <= '0;
         fill_idx   <= '0;
         core_buf   <= '0;
         drain_buf  <= '0;
         occ_q      <= '0;
         ready_cnt  <= '0;
         proc_cnt   <= '0;
         core_first <= 1'b0;
      end else begin
         if (fill_fire) fill_idx <= fill_idx + 1'b1;
         if (fill_done) fill_buf <= fill_buf + 1'b1;
         if (core_finish) core_buf <= core_buf + 1'b1;
         if (drain_done) drain_buf <= drain_buf + 1'b1;
         occ_q      <= occ_q + cw'(fill_done) - cw'(drain_done);
         ready_cnt  <= ready_cnt + cw'(fill_done) - cw'(core_start);
         proc_cnt   <= proc_cnt + cw'(core_finish) - cw'(drain_start);
         core_first <= core_start;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drain_rd_idx     <= '0;
         drain_rd_all     <= 1'b0;
         rd_inflight      <= 1'b0;
         rd_inflight_last <= 1'b0;
      end else begin
         if (drain_start) begin
            drain_rd_idx <= '0;
            drain_rd_all <= 1'b0;
         end else if (drain_issue) begin
            drain_rd_idx <= drain_rd_idx + 1'b1;
            if (drain_rd_idx == last_idx) drain_rd_all <= 1'b1;
         end
         rd_inflight      <= drain_issue;
         rd_inflight_last <= drain_issue && (drain_rd_idx == last_idx);
      end
   end

   // Two-entry skid FIFO, head always in entry 0. A push lands in the first
   // slot still free after this cycle's pop.
   assign sk_cnt_popped = sk_cnt - {1'b0, out_fire};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sk_cnt   <= 2'd0;
         sk_data0 <= '0;
         sk_data1 <= '0;
         sk_last0 <= 1'b0;
         sk_last1 <= 1'b0;
      end else begin
         if (out_fire) begin
            sk_data0 <= sk_data1;
            sk_last0 <= sk_last1;
         end
         if (rd_inflight) begin
            if (sk_cnt_popped == 2'd0) begin
               sk_data0 <= bus.mem_rdata;
               sk_last0 <= rd_inflight_last;
            end else begin
               sk_data1 <= bus.mem_rdata;
               sk_last1 <= rd_inflight_last;
            end
         end
         sk_cnt <= sk_cnt_popped + {1'b0, rd_inflight};
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.out_data  = sk_data0;
   assign bus.out_last  = out_valid_c && sk_last0;
   assign bus.bufp      = core_buf;
   assign bus.core_busy = core_busy;
   assign bus.core_go   = core_busy && core_first;
   assign bus.field_in  = bus.mem_rdata;
   assign bus.occ       = occ_q;

   assign bus.mem_we    = core_wr || fill_fire;
   assign bus.mem_wadr  = core_wr ? {core_buf, bus.fieldwp} : {fill_buf, fill_idx};
   assign bus.mem_wdata = core_wr ? bus.core_wdata : bus.in_data;
   assign bus.mem_re    = core_rd || drain_issue;
   assign bus.mem_radr  = core_rd ? {core_buf, bus.fieldp} : {drain_buf, drain_rd_idx};
endmodule

// File: tb/tb_patbuf_ctrl.sv
// Randomized bench for patbuf_ctrl. The reference model tracks buffers by
// lifecycle counts (filled, started, processed, drained) and keeps the
// expected contents of every buffer; the field memory is a plain RAM model.
module tb_patbuf_ctrl;
   localparam int bw   = 3;
   localparam int fw   = 5;
   localparam int dw   = 8;
   localparam int nbuf = 1 << bw;
   localparam int nf   = 1 << fw;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   patbuf_ctrl_if #(.bufp_width(bw), .fieldp_width(fw), .buffer_width(dw)) bus();
   patbuf_ctrl #(.bufp_width(bw), .fieldp_width(fw), .buffer_width(dw)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [dw-1:0] mem [0:nbuf*nf-1];
   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_wadr] <= bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_radr];
   end

   int n_checks = 0;
   int n_pass   = 0;

   int n_filled, n_started, n_processed, n_drained;
   int m_fill_idx, dk;
   bit first_busy, rd_pending;
   logic [dw-1:0] rd_expect;
   logic [dw-1:0] ref_data [nbuf][nf];

   int unsigned p_in, p_we, p_re, p_done, p_out;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   task automatic model_clear();
      n_filled = 0; n_started = 0; n_processed = 0; n_drained = 0;
      m_fill_idx = 0; dk = 0; first_busy = 0; rd_pending = 0; rd_expect = '0;
   endtask

   task automatic drive_inputs();
      bus.in_valid   = ($urandom_range(0, 99) < p_in);
      bus.in_data    = dw'($urandom);
      bus.core_we    = ($urandom_range(0, 99) < p_we);
      bus.core_re    = ($urandom_range(0, 99) < p_re);
      bus.core_done  = ($urandom_range(0, 99) < p_done);
      bus.out_ready  = ($urandom_range(0, 99) < p_out);
      bus.fieldp     = fw'($urandom);
      bus.fieldwp    = fw'($urandom);
      bus.core_wdata = dw'($urandom);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"},  32'(bus.in_ready),  32'(0));
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(0));
      chk({tag, "_out_last"},  32'(bus.out_last),  32'(0));
      chk({tag, "_core_go"},   32'(bus.core_go),   32'(0));
      chk({tag, "_core_busy"}, 32'(bus.core_busy), 32'(0));
      chk({tag, "_mem_we"},    32'(bus.mem_we),    32'(0));
      chk({tag, "_mem_re"},    32'(bus.mem_re),    32'(0));
      chk({tag, "_bufp"},      32'(bus.bufp),      32'(0));
      chk({tag, "_occ"},       32'(bus.occ),       32'(0));
   endtask

   // One clock: check this cycle's outputs at negedge, then advance the model
   // across the posedge and drive fresh stimulus 1 time unit later.
   task automatic run_cycle();
      bit busy, core_wr, exp_ir, fill_fire, out_fire, start_now;
      int cbuf, fbuf, dbuf;
      @(negedge clk);
      busy = (n_started > n_processed);
      cbuf = n_processed % nbuf;
      fbuf = n_filled % nbuf;
      dbuf = n_drained % nbuf;
      chk("core_busy", 32'(bus.core_busy), 32'(busy));
      chk("core_go",   32'(bus.core_go),   32'(busy && first_busy));
      chk("bufp",      32'(bus.bufp),      32'(cbuf));
      chk("occ",       32'(bus.occ),       32'(n_filled - n_drained));
      core_wr   = busy && bus.core_we;
      exp_ir    = ((n_filled - n_drained) < nbuf) && !core_wr;
      chk("in_ready", 32'(bus.in_ready), 32'(exp_ir));
      fill_fire = bus.in_valid && exp_ir;
      chk("mem_we", 32'(bus.mem_we), 32'(core_wr || fill_fire));
      if (core_wr) begin
         chk("core_wadr",  32'(bus.mem_wadr),  32'(cbuf * nf + int'(bus.fieldwp)));
         chk("core_wdata", 32'(bus.mem_wdata), 32'(bus.core_wdata));
      end else if (fill_fire) begin
         chk("fill_wadr",  32'(bus.mem_wadr),  32'(fbuf * nf + m_fill_idx));
         chk("fill_wdata", 32'(bus.mem_wdata), 32'(bus.in_data));
      end
      if (busy && bus.core_re) begin
         chk("core_re",   32'(bus.mem_re),   32'(1));
         chk("core_radr", 32'(bus.mem_radr), 32'(cbuf * nf + int'(bus.fieldp)));
      end
      if (rd_pending) chk("field_in", 32'(bus.field_in), 32'(rd_expect));
      if (n_processed == n_drained) chk("out_valid_idle", 32'(bus.out_valid), 32'(0));
      out_fire = bus.out_valid && bus.out_ready;
      if (out_fire) begin
         chk("out_data", 32'(bus.out_data), 32'(ref_data[dbuf][dk]));
         chk("out_last", 32'(bus.out_last), 32'(dk == nf - 1));
      end
      @(posedge clk);
      rd_pending = busy && bus.core_re;
      if (rd_pending) rd_expect = ref_data[cbuf][bus.fieldp];
      if (core_wr) ref_data[cbuf][bus.fieldwp] = bus.core_wdata;
      start_now = !busy && (n_filled > n_started);
      if (fill_fire) begin
         ref_data[fbuf][m_fill_idx] = bus.in_data;
         m_fill_idx++;
         if (m_fill_idx == nf) begin
            m_fill_idx = 0;
            n_filled++;
         end
      end
      if (busy && bus.core_done) n_processed++;
      if (start_now) n_started++;
      first_busy = start_now;
      if (out_fire) begin
         dk++;
         if (dk == nf) begin
            dk = 0;
            n_drained++;
         end
      end
      #1;
      drive_inputs();
   endtask

   // Called at posedge+1: asynchronous reset lands mid-cycle with every
   // request input active, outputs must drop at once.
   task automatic reset_mid(input string tag);
      #2;
      bus.in_valid = 1'b1; bus.core_we = 1'b1; bus.core_re = 1'b1;
      bus.core_done = 1'b1; bus.out_ready = 1'b1;
      reset = 1'b0;
      #1;
      check_reset_outputs(tag);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      model_clear();
      drive_inputs();
   endtask

   initial begin
      bit found;
      for (int i = 0; i < nbuf * nf; i++) mem[i] = '0;
      for (int b = 0; b < nbuf; b++)
         for (int f = 0; f < nf; f++) ref_data[b][f] = '0;
      model_clear();
      p_in = 100; p_we = 100; p_re = 100; p_done = 100; p_out = 100;
      drive_inputs();
      #12;
      check_reset_outputs("por");
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Core never finishes: ring fills to NBUF and fill stalls.
      p_in = 100; p_we = 20; p_re = 50; p_done = 0; p_out = 100;
      drive_inputs();
      repeat (600) run_cycle();
      chk("ring_full_occ",      32'(bus.occ),      32'(nbuf));
      chk("ring_full_in_ready", 32'(bus.in_ready), 32'(0));

      p_in = 70; p_we = 25; p_re = 50; p_done = 5; p_out = 60;
      repeat (3000) run_cycle();

      p_in = 60; p_done = 5;
      found = 0;
      for (int i = 0; i < 2000 && !found; i++) begin
         run_cycle();
         found = (m_fill_idx >= 5 && m_fill_idx <= 20);
      end
      chk("wait_mid_fill", 32'(found), 32'(1));
      reset_mid("fill_rst");

      p_in = 70; p_done = 8; p_out = 60;
      repeat (1500) run_cycle();

      p_in = 80; p_done = 10; p_out = 50;
      found = 0;
      for (int i = 0; i < 3000 && !found; i++) begin
         run_cycle();
         found = (dk >= 5 && dk <= 20);
      end
      chk("wait_mid_drain", 32'(found), 32'(1));
      reset_mid("drain_rst");

      p_in = 75; p_we = 30; p_done = 6; p_out = 70;
      repeat (1500) run_cycle();

      p_in = 0; p_done = 20; p_out = 100;
      found = 0;
      for (int i = 0; i < 4000 && !found; i++) begin
         run_cycle();
         found = (n_drained == n_filled) && (n_started == n_processed);
      end
      chk("drain_all", 32'(found), 32'(1));
      chk("final_occ", 32'(bus.occ), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
